// File: rtl/bram_wrap_single.sv
// bram_wrap_single: single-port BRAM adapter for a req/gnt/r_valid data bus.
// Requests go to the BRAM in the same cycle, with no added register stage.
// Responses come back in order, READ_LATENCY cycles later, with no bubbles.
//
// Handshake: a request transfers on a clock edge when data_req_i and
// data_gnt_o are both high. data_gnt_o is high in every cycle outside reset,
// so this block never applies back-pressure. Each transfer produces exactly
// one data_r_valid_o pulse, READ_LATENCY cycles after its grant edge. The
// response has no ready signal, so the requester must always accept it.
module bram_wrap_single #(
  parameter int ID_WIDTH     = 2,
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int BE_WIDTH     = DATA_WIDTH / 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // request side
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_add_i,
  input  logic                  data_wen_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  output logic                  data_gnt_o,
  // response side
  output logic                  data_r_valid_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata_o,
  // BRAM port A
  output logic [ADDR_WIDTH-1:0] ADDRA_o,
  output logic [DATA_WIDTH-1:0] DINA_o,
  input  logic [DATA_WIDTH-1:0] DOUTA_i,
  output logic                  ENA_o,
  output logic                  WEA_o
);

  // Pipeline depth follows the BRAM output latency. Only 1 and 2 are legal;
  // any larger value is clamped to 2. ID_WIDTH has no function in this
  // block, and the ID_WIDTH term below is always true.
  localparam int LAT = (ID_WIDTH >= 0 && READ_LATENCY >= 2) ? 2 : 1;

  logic           req_fire;
  logic [LAT-1:0] vld_q;   // per-stage response-valid flag
  logic [LAT-1:0] ld_q;    // per-stage "response belongs to a load"

  // Grant is simply "out of reset". The first request is therefore
  // accepted in the first cycle after rst_n rises.
  assign data_gnt_o = rst_n;
  assign req_fire   = data_req_i & data_gnt_o;

  // Combinational request mapping onto the BRAM port.
  // A store with no byte enables drives no write strobe, but it still
  // produces a response. Any nonzero byte enable writes the full word,
  // because the BRAM has a single write-enable bit.
  always_comb begin
    ENA_o   = req_fire;
    WEA_o   = req_fire & ~data_wen_i & (|data_be_i);
    ADDRA_o = data_add_i;
    DINA_o  = data_wdata_i;
  end

  // Response tracking pipeline: {valid, is_load} shifts once per cycle.
  // Reset clears it, so in-flight responses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      ld_q  <= '0;
    end else begin
      vld_q[0] <= req_fire;
      ld_q[0]  <= req_fire & data_wen_i;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        ld_q[i]  <= ld_q[i-1];
      end
    end
  end

  // Response output. Load data is muxed straight from DOUTA_i so that the
  // total load latency equals the BRAM latency. The data bus reads zero for
  // store responses and in idle cycles.
  always_comb begin
    data_r_valid_o = vld_q[LAT-1];
    data_r_rdata_o = '0;
    if (vld_q[LAT-1] && ld_q[LAT-1]) data_r_rdata_o = DOUTA_i;
  end

endmodule

// File: tb/tb_bram_wrap_single.sv
// tb_bram_wrap_single: randomized and directed check of bram_wrap_single.
// The bench includes a behavioural BRAM model and a word-level reference.
module tb_bram_wrap_single;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int RL    = 1;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          data_req_i = 1'b0;
  logic [AW-1:0] data_add_i = '0;
  logic          data_wen_i = 1'b0;
  logic [DW-1:0] data_wdata_i = '0;
  logic [BW-1:0] data_be_i = '0;
  logic          data_gnt_o;
  logic          data_r_valid_o;
  logic [DW-1:0] data_r_rdata_o;
  logic [AW-1:0] ADDRA_o;
  logic [DW-1:0] DINA_o;
  logic [DW-1:0] DOUTA_i;
  logic          ENA_o;
  logic          WEA_o;

  bram_wrap_single #(
    .ID_WIDTH(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_gnt_o(data_gnt_o),
    .data_r_valid_o(data_r_valid_o), .data_r_rdata_o(data_r_rdata_o),
    .ADDRA_o(ADDRA_o), .DINA_o(DINA_o), .DOUTA_i(DOUTA_i), .ENA_o(ENA_o), .WEA_o(WEA_o)
  );

  // ---------------- BRAM model (read-first, initialised to 0) ----------------
  logic [DW-1:0] bram [DEPTH] = '{default: '0};
  logic [DW-1:0] dout_p [2] = '{default: '0};
  always @(posedge clk) begin
    if (ENA_o) begin
      dout_p[0] <= bram[ADDRA_o];
      if (WEA_o) bram[ADDRA_o] <= DINA_o;
    end
    dout_p[1] <= dout_p[0];
  end
  assign DOUTA_i = dout_p[RL-1];

  // ---------------- reference model and scoreboard ----------------
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q[$];   // expected response data, in order
  int            due_q[$];   // cycle in which each response is due
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Drive one cycle of bus activity, check the outputs at the falling edge,
  // then advance to just after the next rising edge.
  task automatic do_req(input logic req, input logic wen, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    data_req_i   = req;
    data_wen_i   = wen;
    data_add_i   = addr;
    data_wdata_i = wdata;
    data_be_i    = be;
    if (rst_n && req) begin
      if (wen) exp_q.push_back(ref_mem[addr]);
      else begin
        exp_q.push_back('0);
        if (be != '0) ref_mem[addr] = wdata;
      end
      due_q.push_back(cyc + RL);
    end
    @(negedge clk);
    chk("gnt", 64'(data_gnt_o), 64'(rst_n));
    chk("ena", 64'(ENA_o), 64'(req & rst_n));
    chk("wea", 64'(WEA_o), 64'(req & rst_n & ~wen & (be != '0)));
    chk("addra", 64'(ADDRA_o), 64'(addr));
    chk("dina", 64'(DINA_o), 64'(wdata));
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      chk("r_valid", 64'(data_r_valid_o), 64'd1);
      chk("r_rdata", 64'(data_r_rdata_o), 64'(exp_q[0]));
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
    end else begin
      chk("r_valid_idle", 64'(data_r_valid_o), 64'd0);
      chk("r_rdata_idle", 64'(data_r_rdata_o), 64'd0);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_req(1'b0, 1'b0, AW'($urandom_range(0, 31)), $urandom, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && due_q.size() > 0; i++) idle(1);
    chk("drain_left", 64'(due_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset: grant low and the BRAM untouched, even with a request presented.
    do_req(1'b1, 1'b0, 10'd7, 32'h1234_5678, 4'hF);
    do_req(1'b1, 1'b1, 10'd7, 32'h0, 4'hF);
    rst_n = 1'b1;

    // Store words 0..15, then load 0..19 back-to-back.
    for (int i = 0; i < 16; i++) do_req(1'b1, 1'b0, AW'(i), DW'(i), 4'hF);
    for (int i = 0; i < 20; i++) do_req(1'b1, 1'b1, AW'(i), $urandom, 4'hF);
    drain();

    // Isolated loads separated by idle gaps.
    for (int i = 0; i < 20; i++) begin
      do_req(1'b1, 1'b1, AW'(i), '0, 4'hF);
      idle($urandom_range(1, 3));
    end
    drain();

    // A store with no byte enables leaves memory unchanged but still responds.
    do_req(1'b1, 1'b0, 10'd3, 32'hA5A5_0001, 4'h0);
    do_req(1'b1, 1'b1, 10'd3, '0, 4'hF);
    drain();

    // A load in the cycle right after a store to the same address.
    do_req(1'b1, 1'b0, 10'd5, 32'hDEAD_BEEF, 4'hF);
    do_req(1'b1, 1'b1, 10'd5, '0, 4'hF);
    drain();

    // Randomized mix over a small address window, so collisions occur.
    for (int i = 0; i < 300; i++) begin
      do_req(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             AW'($urandom_range(0, 31)), $urandom,
             ($urandom_range(0, 3) == 0) ? BW'(0) : BW'($urandom_range(1, 15)));
    end
    drain();

    // A reset that lands after the grant edge drops the pending response.
    do_req(1'b1, 1'b1, 10'd5, '0, 4'hF);
    rst_n = 1'b0;
    exp_q.delete();
    due_q.delete();
    do_req(1'b1, 1'b1, 10'd5, '0, 4'hF);
    do_req(1'b1, 1'b0, 10'd6, 32'h0BAD_0BAD, 4'hF);
    rst_n = 1'b1;
    do_req(1'b1, 1'b1, 10'd5, '0, 4'hF);
    do_req(1'b1, 1'b1, 10'd6, '0, 4'hF);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit, so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bram_wrap_single.md
BRAM_WRAP_SINGLE -- requirements
Module: bram_wrap_single

Interface
REQ-001 The block SHALL have parameter ID_WIDTH, default 2, unused by the logic and kept for interconnect compatibility.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, word-address width; memory depth is 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-004 The block SHALL have parameter BE_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-005 The block SHALL have parameter READ_LATENCY, default 1 (legal: 1 or 2), BRAM clock-to-DOUTA latency.
REQ-006 clk  in  1  single clock for all logic; BRAM shares it.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 data_req_i  in  1  request valid.
REQ-009 data_add_i  in  ADDR_WIDTH  word address, consecutive words differ by 1 (no byte offset).
REQ-010 data_wen_i  in  1  request type: 0 = store, 1 = load.
REQ-011 data_wdata_i  in  DATA_WIDTH  store data.
REQ-012 data_be_i  in  BE_WIDTH  byte enables.
REQ-013 data_gnt_o  out  1  request granted.
REQ-014 data_r_valid_o  out  1  response valid, for loads and stores.
REQ-015 data_r_rdata_o  out  DATA_WIDTH  load response data.
REQ-016 ADDRA_o  out  ADDR_WIDTH  BRAM address.
REQ-017 DINA_o  out  DATA_WIDTH  BRAM write data.
REQ-018 DOUTA_i  in  DATA_WIDTH  BRAM read data.
REQ-019 ENA_o  out  1  BRAM enable.
REQ-020 WEA_o  out  1  BRAM write enable, single bit with no byte-write support.

Function
REQ-021 data_gnt_o SHALL be 0 while rst_n=0 and 1 in every cycle after reset release; every request is accepted in its request cycle, with no back-pressure.
REQ-022 Request mapping SHALL be combinational with no added cycle: ENA_o = data_req_i & data_gnt_o; ADDRA_o = data_add_i; DINA_o = data_wdata_i.
REQ-023 WEA_o SHALL be data_req_i & data_gnt_o & ~data_wen_i & (|data_be_i).
REQ-024 A store with any byte-enable bit set SHALL write the full word to memory.
REQ-025 A store with data_be_i=0 SHALL write nothing but SHALL still complete and return a response.
REQ-026 Each granted request SHALL produce exactly one data_r_valid_o pulse, exactly READ_LATENCY cycles after the grant edge; responses return in order.
REQ-027 A valid/type pipeline SHALL track READ_LATENCY stages of {valid, is_load}.
REQ-028 For a load response, data_r_rdata_o SHALL equal DOUTA_i in the data_r_valid_o cycle, i.e. the memory content at the granted address before any same-cycle write.
REQ-029 For a store response, data_r_rdata_o SHALL be 0.
REQ-030 Outside data_r_valid_o cycles, data_r_rdata_o SHALL be 0.
REQ-031 data_r_rdata_o SHALL be driven through a mux from DOUTA_i, not re-registered, so that total load latency equals READ_LATENCY.
REQ-032 Back-to-back requests, one per cycle in any load/store mix, SHALL yield back-to-back responses with no bubbles.
REQ-033 A load immediately following a store to the same address SHALL return the newly stored value.
REQ-034 Addresses SHALL be used modulo 2**ADDR_WIDTH; no address out of range exists.
REQ-035 With data_req_i=0, ENA_o and WEA_o SHALL be 0 and no response SHALL be generated.

Reset
REQ-036 While rst_n=0: data_gnt_o=0, data_r_valid_o=0, data_r_rdata_o=0, ENA_o=0, WEA_o=0, and the response pipeline is cleared.
REQ-037 Reset asserted mid-operation SHALL discard in-flight responses; no data_r_valid_o may appear after reset for a request issued before it.
REQ-038 Memory contents are not reset by this block.
REQ-039 The first request SHALL be accepted in the first cycle after rst_n rises.

Verification
REQ-040 Store addresses 0..15 with data 0..15 (be=4'hF), one per cycle -> WEA_o high for 16 cycles and 16 r_valid pulses with rdata=0.
REQ-041 Then load addresses 0..19 back-to-back -> rdata 0..15 for addresses 0..15; addresses 16..19 return the BRAM init value (0 in the sim model); each pulse is READ_LATENCY cycles after its request.
REQ-042 Isolated single loads of addresses 0..19 with idle gaps -> same values as REQ-041, one r_valid per load, none when idle.
REQ-043 Store 32'hA5A5_0001 to address 3 with be=0, then load address 3 -> previous value 3 returned; store response still issued.
REQ-044 Store 32'hDEAD_BEEF to address 5, then load address 5 on the next cycle -> 32'hDEAD_BEEF.
REQ-045 Issue a load, assert rst_n=0 before its response cycle -> no r_valid_o pulse; gnt_o=0 during reset; gnt_o=1 in the first cycle after release.
